// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end: word widths, default
// reset PC, the bubble encoding and the fetch-path selection type.
package cpu_pkg;

    localparam int          WORD_W       = 32;
    localparam int          JUMP_INDEX_W = 26;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Which rule governs the next fetch edge, highest priority first.
    typedef enum logic [2:0] {
        SEL_JUMP   = 3'd0,
        SEL_BRANCH = 3'd1,
        SEL_FLUSH  = 3'd2,
        SEL_STALL  = 3'd3,
        SEL_SEQ    = 3'd4
    } fetch_sel_e;

    // A byte address is word-misaligned when either of its low two bits is set.
    function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ifid_pipeline_register.sv
// IF/ID pipeline register: holds the fetched instruction, its PC+4 and a
// valid flag. Bubble has priority over load; with neither, contents hold.
module ifid_pipeline_register
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic [WORD_W-1:0] i_instruction,
    input  logic [WORD_W-1:0] i_pc_plus4,
    output logic [WORD_W-1:0] o_instruction,
    output logic [WORD_W-1:0] o_pc_plus4,
    output logic              o_valid
);

    logic [WORD_W-1:0] r_instruction;
    logic [WORD_W-1:0] r_pc_plus4;
    logic              r_valid;

    // Register update: reset/bubble insert a NOP, load captures the fetch, else hold.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_instruction <= NOP_WORD;
            r_pc_plus4    <= 32'h0000_0000;
            r_valid       <= 1'b0;
        end else if (i_bubble) begin
            r_instruction <= NOP_WORD;
            r_pc_plus4    <= 32'h0000_0000;
            r_valid       <= 1'b0;
        end else if (i_load) begin
            r_instruction <= i_instruction;
            r_pc_plus4    <= i_pc_plus4;
            r_valid       <= 1'b1;
        end else begin
            r_instruction <= r_instruction;
            r_pc_plus4    <= r_pc_plus4;
            r_valid       <= r_valid;
        end
    end

    assign o_instruction = r_instruction;
    assign o_pc_plus4    = r_pc_plus4;
    assign o_valid       = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory, applies
// jump/branch redirects, stall and flush, and fills the IF/ID register.
// Also keeps a saturating count of delivered instructions and a sticky
// flag for misaligned branch targets.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC    = RESET_PC_DEF,
    parameter int                COUNT_WIDTH = 16,
    parameter logic [WORD_W-1:0] NOP_WORD    = NOP_WORD_DEF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Stall,
    input  logic                    Flush,
    input  logic                    BranchTaken,
    input  logic [WORD_W-1:0]       BranchTarget,
    input  logic                    Jump,
    input  logic [JUMP_INDEX_W-1:0] JumpIndex,
    input  logic [WORD_W-1:0]       IMemInstruction,
    output logic [WORD_W-1:0]       IMemAddress,
    output logic [WORD_W-1:0]       IFID_Instruction,
    output logic [WORD_W-1:0]       IFID_PCPlus4,
    output logic                    IFID_Valid,
    output logic [COUNT_WIDTH-1:0]  FetchCount,
    output logic                    AlignErr
);

    logic [WORD_W-1:0]      r_pc;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_align_err;

    fetch_sel_e             w_sel;
    logic [WORD_W-1:0]      w_pc_plus4;
    logic [WORD_W-1:0]      w_jump_target;
    logic [WORD_W-1:0]      w_branch_target;
    logic [WORD_W-1:0]      w_pc_next;
    logic                   w_ifid_load;
    logic                   w_ifid_bubble;
    logic                   w_count_inc;
    logic                   w_align_set;

    // Sequential PC wraps modulo 2^32; jump stays in the 256 MB region of the
    // instruction in decode; branch targets are forced to word alignment.
    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_jump_target   = {IFID_PCPlus4[31:28], JumpIndex, 2'b00};
    assign w_branch_target = {BranchTarget[31:2], 2'b00};

    // Priority decode of the control inputs; redirects beat flush and stall.
    always_comb begin
        w_sel = SEL_SEQ;
        if (Jump) begin
            w_sel = SEL_JUMP;
        end else if (BranchTaken) begin
            w_sel = SEL_BRANCH;
        end else if (Flush) begin
            w_sel = SEL_FLUSH;
        end else if (Stall) begin
            w_sel = SEL_STALL;
        end else begin
            w_sel = SEL_SEQ;
        end
    end

    // Next-PC mux and IF/ID / counter controls for the selected rule.
    always_comb begin
        w_pc_next     = r_pc;
        w_ifid_load   = 1'b0;
        w_ifid_bubble = 1'b0;
        w_count_inc   = 1'b0;
        case (w_sel)
            SEL_JUMP: begin
                w_pc_next     = w_jump_target;
                w_ifid_bubble = 1'b1;
            end
            SEL_BRANCH: begin
                w_pc_next     = w_branch_target;
                w_ifid_bubble = 1'b1;
            end
            SEL_FLUSH: begin
                w_pc_next     = Stall ? r_pc : w_pc_plus4;
                w_ifid_bubble = 1'b1;
            end
            SEL_STALL: begin
                w_pc_next     = r_pc;
            end
            SEL_SEQ: begin
                w_pc_next     = w_pc_plus4;
                w_ifid_load   = 1'b1;
                w_count_inc   = 1'b1;
            end
            default: begin
                w_pc_next     = r_pc;
                w_ifid_bubble = 1'b1;
            end
        endcase
    end

    // Only a branch can carry a misaligned target; jump targets are built aligned.
    assign w_align_set = (w_sel == SEL_BRANCH) && is_misaligned(BranchTarget);

    // Program counter register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Saturating count of real instructions delivered to decode.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_count <= '0;
        end else if (w_count_inc && !(&r_count)) begin
            r_count <= r_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_align_err <= 1'b0;
        end else if (w_align_set) begin
            r_align_err <= 1'b1;
        end else begin
            r_align_err <= r_align_err;
        end
    end

    ifid_pipeline_register #(
        .NOP_WORD (NOP_WORD)
    ) u_ifid (
        .Clk           (Clk),
        .Reset         (Reset),
        .i_load        (w_ifid_load),
        .i_bubble      (w_ifid_bubble),
        .i_instruction (IMemInstruction),
        .i_pc_plus4    (w_pc_plus4),
        .o_instruction (IFID_Instruction),
        .o_pc_plus4    (IFID_PCPlus4),
        .o_valid       (IFID_Valid)
    );

    assign IMemAddress = r_pc;
    assign FetchCount  = r_count;
    assign AlignErr    = r_align_err;

endmodule
